led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter DWELL, default 1000, cycles each row is driven; legal range 1..65535.
REQ-002 Parameter BLANK, default 16, all-off cycles before each row is driven; legal range 1..65535.
REQ-003 CLK  input  1  single clock for the whole block; all flops on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 frame  input  96  LED bitmap; bit 12*r+c is row r (0..7), column c (0..11).
REQ-006 frame_valid  input  1  qualifies frame for one cycle.
REQ-007 row_sel  output  8  one-hot row drive, active-high; bit r selects row r.
REQ-008 col  output  12  column drive, active-high; col[c] lights column c of the selected row.
REQ-009 frame_ack  output  1  one-cycle pulse: a pending frame moved into the display buffer.
REQ-010 frame_start  output  1  one-cycle pulse on the first DRIVE cycle of row 0.

Function
REQ-011 All outputs shall be registered.
REQ-012 The block shall hold two 96-bit buffers: pend_buf (latest received) and disp_buf (being scanned).
REQ-013 On any edge with frame_valid=1, pend_buf shall take frame and the pending flag shall set; a later frame_valid before a swap overwrites pend_buf (latest wins).
REQ-014 The FSM shall have the states IDLE, BLANK and DRIVE, with a row index 0..7 and a dwell counter sized for max(DWELL,BLANK).
REQ-015 IDLE: row_sel=0 and col=0; on an edge with pending=1, perform a swap, set row=0 and enter BLANK.
REQ-016 Swap: disp_buf takes pend_buf, pending clears and frame_ack=1 for exactly that one following cycle.
REQ-017 BLANK: row_sel=0 and col=0 for exactly BLANK cycles, then enter DRIVE.
REQ-018 DRIVE: row_sel has only bit row set and col[c]=disp_buf[12*row+c], for exactly DWELL cycles.
REQ-019 At the end of DRIVE with row<7: increment row and enter BLANK.
REQ-020 At the end of DRIVE with row=7: wrap row to 0; if pending=1, swap; enter BLANK either way.
REQ-021 disp_buf shall change only at a frame boundary (the row 7 -> row 0 transition) or on leaving IDLE; a mid-scan frame_valid never alters the rows currently being scanned.
REQ-022 frame_valid on the same edge as a swap: the swap uses the old pend_buf; the new frame loads into pend_buf and pending stays 1, so that frame shows after the next boundary.
REQ-023 After the first frame, the block shall never return to IDLE and shall rescan disp_buf indefinitely while no new frame arrives.
REQ-024 Exactly one row_sel bit shall be high during DRIVE and none at any other time.
REQ-025 One full frame scan shall be 8*(BLANK+DWELL) cycles.
REQ-026 Latency: frame_valid at edge t in IDLE -> frame_ack high after edge t+1 -> row_sel=8'h01 first visible after edge t+1+BLANK.

Reset
REQ-027 While RST=0 (asynchronous), the block shall hold: state=IDLE, row=0, counter=0, pending=0, pend_buf=0, disp_buf=0, row_sel=0, col=0, frame_ack=0, frame_start=0.
REQ-028 Reset asserted mid-scan shall blank all outputs immediately, without waiting for a clock edge.
REQ-029 After reset release, the block shall stay in IDLE until the first frame_valid; frames presented during reset are lost.

Verification (DWELL=4, BLANK=2)
REQ-030 Reset release, no frame_valid for 100 cycles -> row_sel=0, col=0, frame_ack never pulses.
REQ-031 frame bit 0 set (row 0, col 0) with one frame_valid pulse -> frame_ack 1 cycle; 2 blank cycles; row_sel=8'h01 with col=12'h001 for 4 cycles plus a frame_start pulse; rows 1..7 each driven with col=0; pattern repeats every 48 cycles.
REQ-032 frame bit 95 set -> row_sel=8'h80 with col=12'h800 for 4 of every 48 cycles; all other rows show col=0.
REQ-033 Frame A displaying; frame B pulsed during row 3, then frame C during row 5 -> rows 3..7 still show A; from the next row 0, C shows; B never shows; exactly one frame_ack.
REQ-034 frame_valid on the exact swap edge -> old pending frame shows this scan; the new frame shows after the following boundary, with a frame_ack at each boundary.
REQ-035 RST low during row 4 DRIVE -> row_sel and col clear immediately; after release, IDLE until the next frame_valid.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// ----------------------------------------------------------------------------
// LedMatrixScanner -- drives an 8-row x 12-column LED matrix one row at a time.
//
// A new bitmap is captured into a pending buffer whenever frame_valid is high.
// The scan is double-buffered. The pending bitmap moves into the display
// buffer only when the block leaves IDLE, or at the wrap from row 7 to row 0.
// This means a frame that is half way through its scan is never torn.
// Each row gets BLANK all-off cycles first, then DWELL cycles of drive.
//
// Parameters
//   DWELL        cycles each row is driven (1..65535)
//   BLANK        all-off cycles ahead of each row (1..65535)
// Ports
//   CLK          clock, all flops on the rising edge
//   RST          asynchronous, active-low reset
//   frame        96-bit bitmap, bit 12*r+c = row r, column c
//   frame_valid  qualifies frame for one cycle
//   row_sel      one-hot row drive (registered)
//   col          column drive for the selected row (registered)
//   frame_ack    one-cycle pulse when the pending frame enters the display buffer
//   frame_start  one-cycle pulse on the first drive cycle of row 0
// ----------------------------------------------------------------------------
module led_matrix_scanner #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [95:0] frame,
    input  logic        frame_valid,
    output logic [7:0]  row_sel,
    output logic [11:0] col,
    output logic        frame_ack,
    output logic        frame_start
);

    // The counter only ever reaches max(DWELL,BLANK)-1.
    localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic [95:0]   pend_q, pend_d;
    logic [95:0]   disp_q, disp_d;
    logic [7:0]    row_sel_q, row_sel_d;
    logic [11:0]   col_q, col_d;
    logic          ack_q, ack_d;
    logic          start_q, start_d;
    logic          swap;

    // Next-state logic. The outputs are derived from the next state, so the
    // registered outputs always line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        swap      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    swap    = 1'b1;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                    if (row_q == 3'd7) begin
                        // A frame boundary is the only point where the scan
                        // may pick up a new bitmap.
                        row_d = 3'd0;
                        swap  = pending_q;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A swap reads the old pending buffer. A frame that arrives on that
        // same edge becomes the next pending frame.
        pend_d    = frame_valid ? frame : pend_q;
        pending_d = frame_valid ? 1'b1 : (swap ? 1'b0 : pending_q);
        disp_d    = swap ? pend_q : disp_q;

        row_sel_d = 8'd0;
        col_d     = 12'd0;
        if (state_d == ST_DRIVE) begin
            row_sel_d = 8'd1 << row_d;
            col_d     = disp_d[7'(row_d) * 7'd12 +: 12];
        end
        ack_d   = swap;
        start_d = (state_q == ST_BLANK) && (state_d == ST_DRIVE) && (row_q == 3'd0);
    end

    // State and output registers. Reset blanks the matrix immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            row_q     <= 3'd0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            pend_q    <= 96'd0;
            disp_q    <= 96'd0;
            row_sel_q <= 8'd0;
            col_q     <= 12'd0;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign col         = col_q;
    assign frame_ack   = ack_q;
    assign frame_start = start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// ----------------------------------------------------------------------------
// TbLedMatrixScanner -- self-checking bench for led_matrix_scanner with
// DWELL=4 and BLANK=2. The reference model treats a running scan as a
// position inside a 48-cycle frame period. The expected outputs come from
// that position with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_led_matrix_scanner;

   localparam int DW       = 4;
   localparam int BL       = 2;
   localparam int ROWLEN   = BL + DW;
   localparam int FRAMELEN = 8 * ROWLEN;

   logic        CLK;
   logic        RST;
   logic [95:0] frame;
   logic        frame_valid;
   logic [7:0]  row_sel;
   logic [11:0] col;
   logic        frame_ack;
   logic        frame_start;

   int checkCount = 0;
   int errorCount = 0;
   bit checkEn    = 1'b0;

   bit          mActive  = 1'b0;
   int          mPos     = 0;
   logic [95:0] mDisp    = '0;
   logic [95:0] mPend    = '0;
   bit          mPending = 1'b0;
   bit          mAck     = 1'b0;

   led_matrix_scanner #(
      .DWELL(DW),
      .BLANK(BL)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .frame      (frame),
      .frame_valid(frame_valid),
      .row_sel    (row_sel),
      .col        (col),
      .frame_ack  (frame_ack),
      .frame_start(frame_start)
   );

   // Free-running 10-unit clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Every comparison in the bench goes through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference model. After each edge, mPos is the position of the coming
   // cycle inside the frame period. The new bitmap is adopted when the model
   // leaves idle or when the position wraps, and only if a frame is pending.
   always @(posedge CLK or negedge RST) begin
      bit doSwap;
      if (!RST) begin
         mActive  = 1'b0;
         mPos     = 0;
         mDisp    = '0;
         mPend    = '0;
         mPending = 1'b0;
         mAck     = 1'b0;
      end else begin
         doSwap = 1'b0;
         if (!mActive) begin
            if (mPending) begin
               doSwap  = 1'b1;
               mActive = 1'b1;
               mPos    = 0;
            end
         end else begin
            mPos = mPos + 1;
            if (mPos == FRAMELEN) begin
               mPos   = 0;
               doSwap = mPending;
            end
         end
         if (doSwap) begin
            mDisp    = mPend;
            mPending = 1'b0;
         end
         if (frame_valid) begin
            mPend    = frame;
            mPending = 1'b1;
         end
         mAck = doSwap;
      end
   end

   // Compare every output against the model on each falling edge, away from
   // the edge that updates the DUT.
   always @(negedge CLK) begin
      logic [7:0]  expRowSel;
      logic [11:0] expCol;
      logic        expStart;
      int          r;
      if (checkEn) begin
         expRowSel = '0;
         expCol    = '0;
         expStart  = 1'b0;
         if (mActive && (mPos % ROWLEN) >= BL) begin
            r         = mPos / ROWLEN;
            expRowSel = 8'(1 << r);
            expCol    = mDisp[12*r +: 12];
            expStart  = (mPos == BL);
         end
         checkOutput("row_sel", 96'(row_sel), 96'(expRowSel));
         checkOutput("col", 96'(col), 96'(expCol));
         checkOutput("frame_ack", 96'(frame_ack), 96'(mAck));
         checkOutput("frame_start", 96'(frame_start), 96'(expStart));
      end
   end

   // Present one frame for exactly one clock, starting at a falling edge.
   task automatic applyStimulus(input logic [95:0] f);
      frame       = f;
      frame_valid = 1'b1;
      @(negedge CLK);
      frame_valid = 1'b0;
   endtask

   // Advance to the falling edge where the running scan sits at position p.
   task automatic waitPos(input int p);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 200) begin
         @(negedge CLK);
         n++;
         hit = mActive && (mPos == p);
      end
      if (!hit) checkOutput("waitPos_timeout", 96'(hit), 96'd1);
   endtask

   function automatic logic [95:0] randFrame();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   // Directed scenarios first, then random frame traffic, then reset in mid-scan.
   initial begin
      RST         = 1'b1;
      frame       = '0;
      frame_valid = 1'b0;
      #1 RST = 1'b0;
      checkEn = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b1;

      // Without any frame the block stays dark.
      repeat (100) @(negedge CLK);

      // A single pixel in the corner at row 0, column 0.
      applyStimulus(96'h1);
      repeat (100) @(negedge CLK);

      // A single pixel in the opposite corner at row 7, column 11.
      applyStimulus(96'h1 << 95);
      repeat (110) @(negedge CLK);

      // Frame A is showing. B arrives during row 3 and C during row 5, so only C follows A.
      waitPos(10);
      applyStimulus(randFrame());
      waitPos(BL);
      waitPos(3 * ROWLEN + BL + 1);
      applyStimulus(randFrame());
      waitPos(5 * ROWLEN + BL + 1);
      applyStimulus(randFrame());
      repeat (100) @(negedge CLK);

      // A new frame lands on the very edge where the scan swaps buffers.
      waitPos(10);
      applyStimulus(randFrame());
      waitPos(FRAMELEN - 1);
      applyStimulus(randFrame());
      repeat (120) @(negedge CLK);

      // Random frame traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            frame       = randFrame();
            frame_valid = 1'b1;
         end else begin
            frame_valid = 1'b0;
         end
         @(negedge CLK);
      end
      frame_valid = 1'b0;

      // Reset during the drive of row 4 blanks the outputs without a clock edge.
      waitPos(4 * ROWLEN + BL);
      #2 RST = 1'b0;
      #1;
      checkOutput("async_row_sel", 96'(row_sel), 96'd0);
      checkOutput("async_col", 96'(col), 96'd0);
      checkOutput("async_ack", 96'(frame_ack), 96'd0);
      checkOutput("async_start", 96'(frame_start), 96'd0);
      @(negedge CLK);
      applyStimulus(randFrame());
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (40) @(negedge CLK);
      applyStimulus(randFrame());
      repeat (80) @(negedge CLK);

      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
